mem_port_arbiter: RTL and testbench

Shares the single byte-wide SimpleMmu-style memory port between the instruction-fetch requester and the data load/store requester of the MIPS core. It serialises 32-bit word accesses into four big-endian byte transfers and assembles read bytes into words. When both requesters are pending, it grants them alternately so neither starves. It sits between the opcode buffer / load-store logic and the memory model, replacing direct per-requester ports.

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one byte-wide memory port between the instruction-fetch requester
// and the data load/store requester. Each 32-bit access becomes four
// big-endian byte transfers. Read bytes are assembled into a word. When both
// requesters are pending, grants alternate between them.
//
// Ports
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   fetch_*        : word-read requester (req level, cancel, done pulse, rdata)
//   data_*         : load/store requester (req level, addr, we, size, wdata,
//                    done/err pulses, zero-extended rdata)
//   busy           : high in XFER and DONE
//   mem_*          : byte-wide memory port (req held until ack)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_cancel,
  output logic                  fetch_done,
  output logic [31:0]           fetch_rdata,
  input  logic                  data_req,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic                  data_we,
  input  logic                  data_size,
  input  logic [31:0]           data_wdata,
  output logic                  data_done,
  output logic [31:0]           data_rdata,
  output logic                  data_err,
  output logic                  busy,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  size_q, size_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            count_q, count_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  cancel_q, cancel_d;

  logic       fetch_elig;
  logic       pick_data;
  logic [1:0] lane;
  logic [2:0] n_bytes;
  logic       fetch_abort;

  // Big-endian: transfer 0 carries the most significant byte.
  assign lane        = 2'd3 - count_q[1:0];
  assign n_bytes     = size_q ? 3'd4 : 3'd1;
  assign fetch_elig  = fetch_req && !fetch_cancel;
  // Tie goes to whoever was not granted last.
  assign pick_data   = data_req && (!fetch_elig || (last_grant_q == GRANT_FETCH));
  // A cancel seen at any point of a fetch byte (including wait cycles) aborts
  // after the current handshake.
  assign fetch_abort = (grant_q == GRANT_FETCH) && (fetch_cancel || cancel_q);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    count_d      = count_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cancel_d     = cancel_q;

    case (state_q)
      ST_IDLE: begin
        err_d    = 1'b0;
        cancel_d = 1'b0;
        if (fetch_elig || data_req) begin
          count_d = 3'd0;
          rdata_d = 32'h0;
          if (pick_data) begin
            grant_d      = GRANT_DATA;
            last_grant_d = GRANT_DATA;
            addr_d       = data_addr;
            we_d         = data_we;
            size_d       = data_size;
            wdata_d      = data_wdata;
            if (data_size && (data_addr[1:0] != 2'b00)) begin
              // Misaligned word: skip the memory and report through DONE.
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_XFER;
            end
          end else begin
            grant_d      = GRANT_FETCH;
            last_grant_d = GRANT_FETCH;
            addr_d       = fetch_addr;
            we_d         = 1'b0;
            size_d       = 1'b1;
            wdata_d      = 32'h0;
            state_d      = ST_XFER;
          end
        end
      end

      ST_XFER: begin
        if (grant_q == GRANT_FETCH && fetch_cancel) begin
          cancel_d = 1'b1;
        end
        if (mem_ack) begin
          if (size_q) begin
            rdata_d[{lane, 3'b000} +: 8] = mem_rdata;
          end else begin
            rdata_d[7:0] = mem_rdata;
          end
          count_d = count_q + 3'd1;
          if (fetch_abort) begin
            state_d = ST_IDLE;
          end else if ((count_q + 3'd1) == n_bytes) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= GRANT_FETCH;
      last_grant_q <= GRANT_FETCH;
      addr_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= 1'b0;
      wdata_q      <= 32'h0;
      count_q      <= 3'd0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      cancel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      count_q      <= count_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cancel_q     <= cancel_d;
    end
  end

  // Outputs decode directly from registered state, so they are all zero while
  // in IDLE and in the cycle after reset.
  assign busy        = (state_q != ST_IDLE);
  assign mem_req     = (state_q == ST_XFER);
  assign mem_addr    = mem_req ? (addr_q + ADDR_WIDTH'(count_q)) : '0;
  assign mem_we      = mem_req && we_q;
  assign mem_wdata   = !mem_we ? 8'h00 :
                       size_q  ? wdata_q[{lane, 3'b000} +: 8] : wdata_q[7:0];

  assign fetch_done  = (state_q == ST_DONE) && (grant_q == GRANT_FETCH);
  assign data_done   = (state_q == ST_DONE) && (grant_q == GRANT_DATA) && !err_q;
  assign data_err    = (state_q == ST_DONE) && (grant_q == GRANT_DATA) && err_q;
  assign fetch_rdata = fetch_done ? rdata_q : 32'h0;
  assign data_rdata  = data_done  ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int K_FETCH = 0;
  localparam int K_DATA  = 1;
  localparam int K_ERR   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, fetch_cancel, fetch_done;
  logic [AW-1:0] fetch_addr;
  logic [31:0]   fetch_rdata;
  logic          data_req, data_we, data_size, data_done, data_err;
  logic [AW-1:0] data_addr;
  logic [31:0]   data_wdata, data_rdata;
  logic          busy, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_cancel(fetch_cancel),
    .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
    .data_size(data_size), .data_wdata(data_wdata), .data_done(data_done),
    .data_rdata(data_rdata), .data_err(data_err), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks after wait_cfg wait cycles of each request.
  logic [7:0] mem [0:511];
  int wait_cfg = 0;
  int wait_cnt = 0;
  assign mem_ack   = mem_req && (wait_cnt == wait_cfg);
  assign mem_rdata = mem[mem_addr[8:0]];
  always @(posedge clk) begin
    if (reset || !mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (mem_req && mem_ack && mem_we) mem[mem_addr[8:0]] <= mem_wdata;
  end

  typedef struct { int kind; logic [31:0] data; bit chk; int cyc; } ev_t;
  typedef struct { logic [31:0] addr; logic we; logic [7:0] wdata; int cyc; } mx_t;
  ev_t evq[$];
  mx_t mxq[$];

  task automatic push_ev(input int kind, input logic [31:0] data, input bit chk, input int c);
    ev_t e;
    e.kind = kind; e.data = data; e.chk = chk; e.cyc = c;
    evq.push_back(e);
  endtask

  task automatic push_xfers(input logic [31:0] base, input int n, input bit word, input logic we,
                            input logic [31:0] wdata, input int first, input int stride);
    mx_t m;
    for (int i = 0; i < n; i++) begin
      m.addr  = base + 32'(i);
      m.we    = we;
      m.wdata = word ? wdata[(24 - 8*i) +: 8] : wdata[7:0];
      m.cyc   = first + i*stride;
      mxq.push_back(m);
    end
  endtask

  // Scoreboard monitor: pops expected events and memory transfers.
  task automatic check_ev(input int kind, input logic [31:0] data);
    ev_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d cycle=%0d data=%h required none", kind, cyc, data);
    end else begin
      e = evq.pop_front();
      if (e.kind != kind || e.cyc != cyc || (e.chk && e.data != data)) begin
        errors++;
        $display("FAIL event got kind=%0d cycle=%0d data=%h required kind=%0d cycle=%0d data=%h",
                 kind, cyc, data, e.kind, e.cyc, e.data);
      end else begin
        $display("event kind=%0d cycle=%0d data=%h ok", kind, cyc, data);
      end
    end
  endtask

  logic          stab_v = 1'b0;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [7:0]    s_wd;
  mx_t           mx;

  always @(negedge clk) begin
    if (fetch_done) check_ev(K_FETCH, fetch_rdata);
    if (data_done)  check_ev(K_DATA, data_rdata);
    if (data_err)   check_ev(K_ERR, 32'h0);
    if (stab_v && mem_req) begin
      checks++;
      if (mem_addr != s_addr || mem_we != s_we || mem_wdata != s_wd) begin
        errors++;
        $display("FAIL stable got addr=%h we=%b wd=%h required addr=%h we=%b wd=%h",
                 mem_addr, mem_we, mem_wdata, s_addr, s_we, s_wd);
      end
    end
    stab_v = mem_req && !mem_ack;
    s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata;
    if (mem_req && mem_ack) begin
      checks++;
      if (mxq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_xfer addr=%h cycle=%0d required none", mem_addr, cyc);
      end else begin
        mx = mxq.pop_front();
        if (mem_addr != mx.addr || mem_we != mx.we || (mx.we && mem_wdata != mx.wdata) || cyc != mx.cyc) begin
          errors++;
          $display("FAIL xfer got addr=%h we=%b wd=%h cycle=%0d required addr=%h we=%b wd=%h cycle=%0d",
                   mem_addr, mem_we, mem_wdata, cyc, mx.addr, mx.we, mx.wdata, mx.cyc);
        end else begin
          $display("xfer addr=%h we=%b wd=%h rd=%h cycle=%0d ok", mem_addr, mem_we, mem_wdata, mem_rdata, cyc);
        end
      end
    end
  end

  task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end else begin
      $display("check %s = %h ok", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int kind);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      hit = (kind == K_FETCH) ? fetch_done : (kind == K_DATA) ? data_done : data_err;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout kind=%0d got no pulse required pulse", kind);
    end
  endtask

  task automatic issue_fetch(input logic [31:0] a, output int k);
    tick();
    fetch_req = 1'b1; fetch_addr = a;
    k = cyc;
  endtask

  task automatic issue_data(input logic [31:0] a, input logic we, input logic sz,
                            input logic [31:0] wd, output int k);
    tick();
    data_req = 1'b1; data_addr = a; data_we = we; data_size = sz; data_wdata = wd;
    k = cyc;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({fetch_done, fetch_rdata, data_done, data_rdata, data_err, busy,
                 mem_req, mem_addr, mem_we, mem_wdata});
  endfunction

  int k;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h100] = 8'h12; mem[9'h101] = 8'h34; mem[9'h102] = 8'h56; mem[9'h103] = 8'h78;
    mem[9'h104] = 8'h9A; mem[9'h105] = 8'hBC; mem[9'h106] = 8'hDE; mem[9'h107] = 8'hF0;
    mem[9'h040] = 8'h01; mem[9'h041] = 8'h02; mem[9'h042] = 8'h03; mem[9'h043] = 8'h04;
    mem[9'h044] = 8'h11; mem[9'h045] = 8'h22; mem[9'h046] = 8'h33; mem[9'h047] = 8'h44;
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0; fetch_cancel = 1'b0;
    data_req = 1'b0; data_addr = '0; data_we = 1'b0; data_size = 1'b0; data_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_outputs", all_outs(), 128'h0);

    // Word fetch, immediate ack.
    issue_fetch(32'h100, k);
    push_xfers(32'h100, 4, 1'b1, 1'b0, 32'h0, k + 1, 1);
    push_ev(K_FETCH, 32'h12345678, 1'b1, k + 5);
    wait_done(K_FETCH);
    fetch_req = 1'b0;

    // Word store then byte load.
    issue_data(32'h20, 1'b1, 1'b1, 32'hAABBCCDD, k);
    push_xfers(32'h20, 4, 1'b1, 1'b1, 32'hAABBCCDD, k + 1, 1);
    push_ev(K_DATA, 32'h0, 1'b0, k + 5);
    @(negedge clk);
    check_eq("busy_idle_cycle", 128'(busy), 128'h0);
    @(negedge clk);
    check_eq("busy_xfer", 128'({busy, mem_we}), 128'h3);
    wait_done(K_DATA);
    data_req = 1'b0;
    issue_data(32'h22, 1'b0, 1'b0, 32'h0, k);
    push_xfers(32'h22, 1, 1'b0, 1'b0, 32'h0, k + 1, 1);
    push_ev(K_DATA, 32'h000000CC, 1'b1, k + 2);
    wait_done(K_DATA);
    data_req = 1'b0;

    // Wait states: ack in the third cycle of each byte request.
    wait_cfg = 2;
    issue_fetch(32'h104, k);
    push_xfers(32'h104, 4, 1'b1, 1'b0, 32'h0, k + 3, 3);
    push_ev(K_FETCH, 32'h9ABCDEF0, 1'b1, k + 13);
    wait_done(K_FETCH);
    fetch_req = 1'b0;
    wait_cfg = 0;

    // Cancel during byte 1 of a fetch; pending data load granted next.
    issue_fetch(32'h100, k);
    push_xfers(32'h100, 1, 1'b1, 1'b0, 32'h0, k + 1, 1);
    push_xfers(32'h101, 1, 1'b0, 1'b0, 32'h0, k + 3, 1);
    push_ev(K_DATA, 32'h00000034, 1'b1, k + 4);
    tick();
    fetch_cancel = 1'b1; fetch_req = 1'b0;
    data_req = 1'b1; data_addr = 32'h101; data_we = 1'b0; data_size = 1'b0;
    tick();
    fetch_cancel = 1'b0;
    @(negedge clk);
    check_eq("cancel_idle", 128'({busy, mem_req}), 128'h0);
    wait_done(K_DATA);
    data_req = 1'b0;

    // Misaligned word load.
    issue_data(32'h41, 1'b0, 1'b1, 32'h0, k);
    push_ev(K_ERR, 32'h0, 1'b0, k + 1);
    wait_done(K_ERR);
    check_eq("misaligned_no_req", 128'(mem_req), 128'h0);
    data_req = 1'b0;

    // Reset asserted during byte 2 of a word store.
    issue_data(32'h30, 1'b1, 1'b1, 32'h11223344, k);
    push_xfers(32'h30, 2, 1'b1, 1'b1, 32'h11223344, k + 1, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_eq("reset_mid_xfer", all_outs(), 128'h0);
    tick();
    reset = 1'b0; data_req = 1'b0; data_we = 1'b0;

    // Contention from reset: data, fetch, data, fetch.
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h100;
    data_req = 1'b1; data_addr = 32'h40; data_we = 1'b0; data_size = 1'b1;
    k = cyc;
    push_xfers(32'h40,  4, 1'b1, 1'b0, 32'h0, k + 1,  1);
    push_xfers(32'h100, 4, 1'b1, 1'b0, 32'h0, k + 7,  1);
    push_xfers(32'h44,  4, 1'b1, 1'b0, 32'h0, k + 13, 1);
    push_xfers(32'h104, 4, 1'b1, 1'b0, 32'h0, k + 19, 1);
    push_ev(K_DATA,  32'h01020304, 1'b1, k + 5);
    push_ev(K_FETCH, 32'h12345678, 1'b1, k + 11);
    push_ev(K_DATA,  32'h11223344, 1'b1, k + 17);
    push_ev(K_FETCH, 32'h9ABCDEF0, 1'b1, k + 23);
    wait_done(K_DATA);
    data_addr = 32'h44;
    wait_done(K_FETCH);
    fetch_addr = 32'h104;
    wait_done(K_DATA);
    data_req = 1'b0;
    wait_done(K_FETCH);
    fetch_req = 1'b0;

    repeat (4) tick();
    check_eq("leftover_expected", 128'(evq.size() + mxq.size()), 128'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
